// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
//
// Requester-facing bus of the ALU arbiter. Groups both request channels, both
// response handshakes and the shared response payload.
//
// Signals:
//   req0_valid/ready, req0_in1/in2/ctrl  requester 0 (main pipeline) operation
//   req1_valid/ready, req1_in1/in2/ctrl  requester 1 (address/branch unit)
//   rsp0_valid/ready, rsp1_valid/ready   per-requester response handshake
//   rsp_result, rsp_zero                 captured ALU result, shared by both
//
// Modports:
//   slave  - the arbiter side (accepts requests, produces responses)
//   master - the requester side (issues requests, consumes responses)
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_in1;
    logic [DATA_WIDTH-1:0] req0_in2;
    logic [CTRL_WIDTH-1:0] req0_ctrl;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_in1;
    logic [DATA_WIDTH-1:0] req1_in2;
    logic [CTRL_WIDTH-1:0] req1_ctrl;

    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_zero;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_in1, req1_in2, req1_ctrl,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_in1, req1_in2, req1_ctrl,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters: the main pipeline (0)
// and the address/branch unit (1). One operation is accepted per transaction
// on a valid/ready handshake, its operands and control are registered towards
// the ALU, the ALU result is captured one cycle later and returned on the
// granted requester's response handshake.
//
// Operation flow: IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold result).
// Minimum three cycles per operation; RESP holds indefinitely under
// backpressure and no new request is accepted until it completes.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   bus          requester/response bus (alu_arbiter_if.slave)
//   busy         high whenever the FSM is not idle
//   alu_in1/2    registered ALU operands
//   alu_control  registered ALU control code (passed through unchecked)
//   alu_result   ALU result input
//   alu_zero     ALU zero flag input
//
// Configuration macro:
//   ROUND_ROBIN_EN  defined   - contention goes to the requester that was not
//                               granted last
//                   undefined - fixed priority, requester 0 always wins
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_arbiter_if.slave          bus,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic [CTRL_WIDTH-1:0] alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_WIDTH-1:0] alu_in2_q, alu_in2_d;
    logic [CTRL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  grant_id_q, grant_id_d;
    logic                  last_grant_q, last_grant_d;

    logic any_valid;
    logic grant;
    logic rsp_taken;

    // ------------------------------------------------------------------------
    // Grant selection (only meaningful while any request is valid)
    // ------------------------------------------------------------------------
    assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ROUND_ROBIN_EN
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            // Lone request always wins; picks 1 only when 0 is idle.
            grant = ~bus.req0_valid;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    assign grant = ~bus.req0_valid;

    // last_grant is kept up to date so both builds have identical state.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    // Only the granted requester's ready matters in RESP.
    assign rsp_taken = grant_id_q ? bus.rsp1_ready : bus.rsp0_ready;

    // ------------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        alu_in1_d      = alu_in1_q;
        alu_in2_d      = alu_in2_q;
        alu_ctrl_d     = alu_ctrl_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        grant_id_d     = grant_id_q;
        last_grant_d   = last_grant_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    bus.req0_ready = ~grant;
                    bus.req1_ready = grant;
                    alu_in1_d      = grant ? bus.req1_in1  : bus.req0_in1;
                    alu_in2_d      = grant ? bus.req1_in2  : bus.req0_in2;
                    alu_ctrl_d     = grant ? bus.req1_ctrl : bus.req0_ctrl;
                    grant_id_d     = grant;
                    last_grant_d   = grant;
                    state_d        = StExec;
                end
            end
            StExec: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                state_d      = StResp;
            end
            StResp: begin
                bus.rsp0_valid = ~grant_id_q;
                bus.rsp1_valid = grant_id_q;
                if (rsp_taken) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_ctrl_q   <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            grant_id_q   <= 1'b0;
            // Starts at 1 so requester 0 wins the first contention.
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign alu_in1        = alu_in1_q;
    assign alu_in2        = alu_in2_q;
    assign alu_control    = alu_ctrl_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A small behavioural ALU sits on the
// alu_* ports. Directed stimulus pushes hand-computed responses into a
// scoreboard queue; an independent monitor pops and compares on every
// response handshake.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          busy;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [CW-1:0] alu_control;
    logic [DW-1:0] alu_result;
    logic          alu_zero;

    alu_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Reference ALU
    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0100: alu_result = alu_in1 - alu_in2;
            4'b1000: alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_hs     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit id, input logic [31:0] res, input logic zero);
        exp_t e;
        e.id   = id;
        e.res  = res;
        e.zero = zero;
        sb.push_back(e);
    endtask

    // Monitor: compares every completed response against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.rsp0_valid && bus.rsp1_valid) begin
                    check("rsp_valid_onehot", 32'd1, 32'd0);
                end else if ((bus.rsp0_valid && bus.rsp0_ready) ||
                             (bus.rsp1_valid && bus.rsp1_ready)) begin
                    n_hs++;
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", {31'd0, bus.rsp1_valid}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", {31'd0, bus.rsp1_valid}, {31'd0, e.id});
                        check("rsp_result", bus.rsp_result, e.res);
                        check("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.zero});
                    end
                end
            end
        end
    end

    // Present a request and wait (bounded) until it is accepted; returns 1ns
    // after the accepting edge with valid dropped.
    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
        bit got = 1'b0;
        if (id) begin
            bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_ctrl = c; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_ctrl = c; bus.req0_valid = 1'b1;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((id && bus.req1_ready) || (!id && bus.req0_ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Expected grant order for contention with both requesters always valid.
    bit exp_order[3];
    int hs_before;
    int acc;

    initial begin
        reset          = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_in1 = '0; bus.req0_in2 = '0; bus.req0_ctrl = '0;
        bus.req1_valid = 1'b0; bus.req1_in1 = '0; bus.req1_in2 = '0; bus.req1_ctrl = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        check("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        check("rst_req_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_ctrl", {28'd0, alu_control}, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        @(posedge clk);
        #1;

        // req0 ADD 23+42: ready at T, response two cycles later
        push(1'b0, 32'd65, 1'b0);
        bus.req0_in1 = 32'd23; bus.req0_in2 = 32'd42; bus.req0_ctrl = 4'b0010;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        check("add_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        check("add_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        check("add_exec_busy", {31'd0, busy}, 32'd1);
        check("add_exec_ctrl", {28'd0, alu_control}, 32'd2);
        check("add_exec_in1", alu_in1, 32'd23);
        check("add_exec_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        @(negedge clk);
        check("add_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        check("add_rsp_no_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        drain();

        // req1 SUB 42-42: response on rsp1 only, zero set
        push(1'b1, 32'd0, 1'b1);
        issue(1'b1, 32'd42, 32'd42, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        check("sub_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        check("sub_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        drain();

        // Contention: req0 AND, req1 OR, both valid continuously
`ifdef ROUND_ROBIN_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            push(exp_order[i], exp_order[i] ? 32'd63 : 32'd2, 1'b0);
        end
        bus.req0_in1 = 32'd23; bus.req0_in2 = 32'd42; bus.req0_ctrl = 4'b0000;
        bus.req1_in1 = 32'd23; bus.req1_in2 = 32'd42; bus.req1_ctrl = 4'b0001;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 60 && acc < 3; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                check("cont_grant", {30'd0, bus.req1_ready, bus.req0_ready},
                      exp_order[acc] ? 32'd2 : 32'd1);
                acc++;
            end
        end
        if (acc < 3) check("cont_accept_timeout", acc, 32'd3);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        // Backpressure: req0 ADD held in RESP while req1 waits
        bus.rsp0_ready = 1'b0;
        push(1'b0, 32'd65, 1'b0);
        push(1'b1, 32'd2, 1'b0);
        issue(1'b0, 32'd42, 32'd23, 4'b0010);
        bus.req1_in1 = 32'd23; bus.req1_in2 = 32'd42; bus.req1_ctrl = 4'b0000;
        bus.req1_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 20 && !bus.rsp0_valid; k++) @(negedge clk);
        check("bp_rsp0_seen", {31'd0, bus.rsp0_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
            check("bp_result_stable", bus.rsp_result, 32'd65);
            check("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus.rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_req1_accept", {31'd0, bus.req1_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        drain();

        // Reset during EXEC drops the op
        issue(1'b0, 32'd1, 32'd2, 4'b0010);
        reset = 1'b1;
        hs_before = n_hs;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_exec_busy", {31'd0, busy}, 32'd0);
        check("rst_exec_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        check("rst_exec_alu_in1", alu_in1, 32'd0);
        check("rst_exec_alu_in2", alu_in2, 32'd0);
        check("rst_exec_alu_ctrl", {28'd0, alu_control}, 32'd0);
        repeat (8) @(negedge clk);
        check("rst_exec_no_rsp", n_hs, hs_before);

        // SLT 42 < 23 is false -> result 0, zero set
        @(posedge clk);
        #1;
        push(1'b0, 32'd0, 1'b1);
        issue(1'b0, 32'd42, 32'd23, 4'b1000);
        @(negedge clk);
        check("slt_exec_ctrl", {28'd0, alu_control}, 32'd8);
        drain();

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
